// File: rtl/sine_burst_ctrl.sv
// Burst sequencer for the sine LUT: accepts {phase_inc, periods, gap} commands,
// steps a phase accumulator for the requested number of full periods, then idles for a gap.
module sine_burst_ctrl #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 16,
    parameter int GAP_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [PHASE_W-1:0] cmd_phase_inc,
    input  logic [CNT_W-1:0]   cmd_cycles,
    input  logic [GAP_W-1:0]   cmd_gap,
    input  logic               abort,
    output logic [ADDR_W-1:0]  lut_addr,
    output logic               lut_en,
    output logic               busy,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic               burst_done,
    output logic               aborted
);

    // state | meaning
    // IDLE  | waiting for a command; cmd_ready unless abort is held
    // RUN   | accumulator stepping, LUT enabled
    // GAP   | post-burst idle time, gap_cnt counting down to zero
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

    state_t state, state_nxt;

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] inc_q;
    logic [CNT_W-1:0]   cycles_q;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_cnt;
    logic [PHASE_W:0]   acc_sum;
    logic               wrap;
    logic               accept;
    logic               run_last;
    logic               gap_last;

    assign acc_sum  = {1'b0, acc} + {1'b0, inc_q};
    assign wrap     = acc_sum[PHASE_W];
    assign accept   = cmd_valid && cmd_ready;
    assign run_last = (state == S_RUN) && wrap && (cycle_cnt == cycles_q - CNT_W'(1));
    assign gap_last = (state == S_GAP) && (gap_cnt == '0);

    // acc is forced to zero outside RUN, so the address is zero there too
    assign lut_addr = acc[PHASE_W-1 -: ADDR_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (cmd_cycles != '0) begin
                            state_nxt = S_RUN;
                        end else if (cmd_gap != '0) begin
                            state_nxt = S_GAP;
                        end
                    end
                end
                S_RUN: begin
                    if (run_last) begin
                        state_nxt = (gap_q != '0) ? S_GAP : S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_last) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ready = rst_n && (state == S_IDLE) && !abort;
        lut_en    = (state == S_RUN);
        busy      = (state == S_RUN) || (state == S_GAP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc        <= '0;
            inc_q      <= '0;
            cycles_q   <= '0;
            gap_q      <= '0;
            gap_cnt    <= '0;
            cycle_cnt  <= '0;
            burst_done <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            aborted    <= 1'b0;
            if (abort && state != S_IDLE) begin
                aborted <= 1'b1;
                acc     <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            inc_q     <= cmd_phase_inc;
                            cycles_q  <= cmd_cycles;
                            gap_q     <= cmd_gap;
                            acc       <= '0;
                            cycle_cnt <= '0;
                            gap_cnt   <= cmd_gap - GAP_W'(1);
                            if (cmd_cycles == '0) begin
                                burst_done <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        acc     <= run_last ? '0 : acc_sum[PHASE_W-1:0];
                        gap_cnt <= gap_q - GAP_W'(1);
                        if (wrap) begin
                            cycle_cnt <= cycle_cnt + CNT_W'(1);
                        end
                        if (run_last) begin
                            burst_done <= 1'b1;
                        end
                    end
                    S_GAP: begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                    default: begin
                        acc <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sine_burst_ctrl.sv
// Bench for sine_burst_ctrl: expected traces come from closed-form arithmetic on
// the command (run length, address and period count per cycle), not from a state machine.
module tb_sine_burst_ctrl;

    typedef logic [30:0] snap_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_phase_inc;
    logic [15:0] cmd_cycles;
    logic [15:0] cmd_gap;
    logic        abort;
    logic [9:0]  lut_addr;
    logic        lut_en;
    logic        busy;
    logic [15:0] cycle_cnt;
    logic        burst_done;
    logic        aborted;

    int checks = 0;
    int errors = 0;
    logic [15:0] last_cnt = '0;
    logic [31:0] nxt_inc;
    logic [15:0] nxt_cyc;
    logic [15:0] nxt_gap;

    sine_burst_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_phase_inc(cmd_phase_inc), .cmd_cycles(cmd_cycles), .cmd_gap(cmd_gap),
        .abort(abort), .lut_addr(lut_addr), .lut_en(lut_en), .busy(busy),
        .cycle_cnt(cycle_cnt), .burst_done(burst_done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    function automatic snap_t snap();
        return {lut_en, busy, cmd_ready, burst_done, aborted, lut_addr, cycle_cnt};
    endfunction

    function automatic snap_t mk(input logic en, input logic bsy, input logic rdy,
                                 input logic done, input logic abt,
                                 input logic [9:0] addr, input logic [15:0] cnt);
        return {en, bsy, rdy, done, abt, addr, cnt};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full command: accept, RUN trace, GAP trace, first IDLE cycle.
    // abort_at >= 0 raises abort during that busy cycle (RUN cycles first, then GAP).
    task automatic run_burst(input logic [31:0] inc, input logic [15:0] cyc,
                             input logic [15:0] gap, input int abort_at,
                             input bit hold, input string name);
        logic [63:0] n;
        logic [63:0] prod;
        logic [15:0] held;
        snap_t exp;
        n = (inc == 0) ? 64'd1000000
                       : (((64'(cyc)) << 32) + 64'(inc) - 64'd1) / 64'(inc);
        cmd_valid     = 1'b1;
        cmd_phase_inc = inc;
        cmd_cycles    = cyc;
        cmd_gap       = gap;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: cmd_ready=%b expected 1", name, cmd_ready);
        end
        step();
        if (hold) begin
            cmd_phase_inc = nxt_inc;
            cmd_cycles    = nxt_cyc;
            cmd_gap       = nxt_gap;
        end else begin
            cmd_valid     = 1'b0;
            cmd_phase_inc = $urandom;
            cmd_cycles    = 16'($urandom);
            cmd_gap       = 16'($urandom);
        end
        for (longint unsigned i = 0; i < n + 64'(gap); i++) begin
            if (i < n) begin
                prod = i * 64'(inc);
                exp  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, prod[31:22], prod[47:32]);
            end else begin
                exp  = mk(1'b0, 1'b1, 1'b0, (i == n), 1'b0, 10'd0, cyc);
            end
            checks++;
            if (snap() !== exp) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %h expected %h", name, i, snap(), exp);
            end
            if (abort_at >= 0 && i == longint'(abort_at)) begin
                prod = i * 64'(inc);
                held = (i < n) ? prod[47:32] : cyc;
                abort = 1'b1;
                step();
                abort = 1'b0;
                #1;
                exp = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd0, held);
                checks++;
                if (snap() !== exp) begin
                    errors++;
                    $display("FAIL %s abort pulse: got %h expected %h", name, snap(), exp);
                end
                step();
                exp = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, held);
                checks++;
                if (snap() !== exp) begin
                    errors++;
                    $display("FAIL %s after abort: got %h expected %h", name, snap(), exp);
                end
                last_cnt = held;
                return;
            end
            step();
        end
        exp = mk(1'b0, 1'b0, 1'b1, (gap == 0), 1'b0, 10'd0, cyc);
        checks++;
        if (snap() !== exp) begin
            errors++;
            $display("FAIL %s idle: got %h expected %h", name, snap(), exp);
        end
        last_cnt = cyc;
    endtask

    task automatic test_reset();
        snap_t exp;
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        abort     = 1'b0;
        cmd_phase_inc = 32'h4000_0000;
        cmd_cycles    = 16'd2;
        cmd_gap       = 16'd0;
        for (int c = 0; c < 3; c++) begin
            step();
            exp = '0;
            checks++;
            if (snap() !== exp) begin
                errors++;
                $display("FAIL reset cycle %0d: got %h expected %h", c, snap(), exp);
            end
        end
        cmd_valid = 1'b0;
        rst_n     = 1'b1;
        #1;
        exp = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 16'd0);
        checks++;
        if (snap() !== exp) begin
            errors++;
            $display("FAIL reset release: got %h expected %h", snap(), exp);
        end
        step();
        last_cnt = '0;
    endtask

    task automatic test_basic();
        run_burst(32'h4000_0000, 16'd2, 16'd0, -1, 1'b0, "basic");
        step();
    endtask

    task automatic test_back_to_back();
        nxt_inc = 32'h4000_0000;
        nxt_cyc = 16'd1;
        nxt_gap = 16'd2;
        run_burst(32'h8000_0000, 16'd1, 16'd5, -1, 1'b1, "gap_hold");
        run_burst(nxt_inc, nxt_cyc, nxt_gap, -1, 1'b0, "b2b_second");
        step();
    endtask

    task automatic test_zero_cycles();
        run_burst(32'h1234_5678, 16'd0, 16'd0, -1, 1'b0, "zero_nogap");
        run_burst(32'h1234_5678, 16'd0, 16'd3, -1, 1'b0, "zero_gap");
    endtask

    task automatic test_abort();
        snap_t exp;
        run_burst(32'h1000_0000, 16'd3, 16'd4, 19, 1'b0, "abort_run");
        run_burst(32'h8000_0000, 16'd1, 16'd6, 4, 1'b0, "abort_gap");
        run_burst(32'h0000_0000, 16'd1, 16'd0, 30, 1'b0, "inc_zero");
        abort     = 1'b1;
        cmd_valid = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            exp = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, last_cnt);
            checks++;
            if (snap() !== exp) begin
                errors++;
                $display("FAIL abort_idle cycle %0d: got %h expected %h", c, snap(), exp);
            end
            step();
        end
        abort     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        exp = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, last_cnt);
        checks++;
        if (snap() !== exp) begin
            errors++;
            $display("FAIL abort_idle release: got %h expected %h", snap(), exp);
        end
    endtask

    task automatic test_reset_mid_run();
        snap_t exp;
        cmd_valid     = 1'b1;
        cmd_phase_inc = 32'h4000_0000;
        cmd_cycles    = 16'd2;
        cmd_gap       = 16'd3;
        step();
        cmd_valid = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        step();
        exp = '0;
        checks++;
        if (snap() !== exp) begin
            errors++;
            $display("FAIL reset_mid_run: got %h expected %h", snap(), exp);
        end
        rst_n = 1'b1;
        #1;
        exp = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 16'd0);
        checks++;
        if (snap() !== exp) begin
            errors++;
            $display("FAIL reset_mid_run release: got %h expected %h", snap(), exp);
        end
        step();
        checks++;
        if (snap() !== exp) begin
            errors++;
            $display("FAIL reset_mid_run no pulse: got %h expected %h", snap(), exp);
        end
        run_burst(32'h4000_0000, 16'd2, 16'd0, -1, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [31:0] inc;
        logic [15:0] cyc;
        logic [15:0] gap;
        int          ab;
        for (int t = 0; t < 10; t++) begin
            inc = $urandom | 32'h0400_0000;
            cyc = 16'($urandom_range(0, 3));
            gap = 16'($urandom_range(0, 6));
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
            run_burst(inc, cyc, gap, ab, 1'b0, "random");
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero_cycles();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sine_burst_ctrl.md
Name: sine_burst_ctrl

Overview:
- Controller that sequences the sine-wave datapath in bursts.
- Accepts a burst command (phase increment, number of full sine periods, idle gap) over a valid/ready handshake.
- Runs a phase accumulator that drives the sine LUT address and enable, counts completed periods, and inserts a programmable gap before accepting the next command.
- Sits between the command/config source and the sine LUT, all in the 100 MHz clock domain.

Parameters:
- PHASE_W, 32, phase accumulator width (bits).
- ADDR_W, 10, sine LUT address width; the address is the top ADDR_W bits of the accumulator.
- CNT_W, 16, width of period count and period counter.
- GAP_W, 16, width of gap length (clock cycles).

Ports:
- clk  input  1  system clock, 100 MHz, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_phase_inc  input  PHASE_W  phase increment per clock.
- cmd_cycles  input  CNT_W  number of full sine periods to generate.
- cmd_gap  input  GAP_W  idle clocks after the burst.
- abort  input  1  terminate any activity, return to IDLE.
- lut_addr  output  ADDR_W  sine LUT address.
- lut_en  output  1  LUT read/output enable.
- busy  output  1  high in RUN or GAP.
- cycle_cnt  output  CNT_W  periods completed in current/last burst.
- burst_done  output  1  one-clock pulse on normal burst completion.
- aborted  output  1  one-clock pulse when abort terminated RUN or GAP.

Behaviour:
- Reset: sampled only on a rising clk edge with rst_n=0. All outputs and state are cleared: state=IDLE, acc=0, lut_addr=0, lut_en=0, busy=0, cycle_cnt=0, burst_done=0, aborted=0, latched command registers=0. cmd_ready=0 while rst_n=0. Reset mid-burst: the burst is dropped silently with no pulse.
- States:
  - IDLE: cmd_ready = !abort; lut_en=0; lut_addr=0.
  - RUN: lut_en=1; busy=1; cmd_ready=0.
  - GAP: lut_en=0; lut_addr=0; busy=1; cmd_ready=0.
- Accept: the handshake completes when cmd_valid && cmd_ready at edge k. The controller latches inc, cycles and gap, clears acc and cycle_cnt.
  - If cycles>0: RUN starts at k+1.
  - If cycles==0: no RUN. burst_done pulses in cycle k+1, state goes to GAP if gap>0, otherwise stays IDLE.
- RUN datapath:
  - lut_addr = acc[PHASE_W-1 -: ADDR_W], registered. The first RUN cycle shows address 0.
  - Each RUN cycle: acc <= acc + inc, mod 2^PHASE_W.
  - A wrap is the carry-out of that sum. Each wrap increments cycle_cnt.
- RUN exit: in the RUN cycle whose update wraps while cycle_cnt == cycles-1, that cycle is the last RUN cycle. Next cycle:
  - cycle_cnt = cycles;
  - burst_done = 1 for exactly one clock;
  - state = GAP if gap>0, else IDLE.
- inc==0: the accumulator never wraps, so the burst runs until abort (legal, not an error).
- GAP: lasts exactly gap clocks, then IDLE. cmd_ready rises on the first IDLE cycle.
- abort:
  - Has priority over everything except reset.
  - From RUN or GAP: next cycle is IDLE, acc=0, lut_en=0, aborted pulses one clock, burst_done does not pulse, cycle_cnt holds its value.
  - In IDLE: cmd_ready is forced low, so no command is accepted and aborted does not pulse.
- Simultaneous events:
  - Abort on the last RUN cycle: abort wins (aborted pulses, burst_done does not).
  - cmd_valid during RUN or GAP: ignored and held by the source, since cmd_ready=0.
- cmd_* inputs are sampled only at the accept edge; later changes have no effect.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks with cmd_valid=1 -> no accept; all outputs 0; cmd_ready=1 on the first clock after rst_n=1.
- Basic burst: inc=2^30, cycles=2, gap=0 ->
  - 8 RUN cycles with lut_en=1, lut_addr sequence 0,256,512,768,0,256,512,768;
  - then burst_done pulse, cycle_cnt=2, IDLE with cmd_ready=1.
- Gap: inc=2^31, cycles=1, gap=5 ->
  - 2 RUN cycles (addr 0,512);
  - burst_done; busy=1 and cmd_ready=0 for exactly 5 clocks, then cmd_ready=1.
  - A back-to-back cmd_valid is accepted only on the first IDLE cycle.
- Zero cycles: cycles=0, gap=0 -> lut_en never asserts; burst_done pulses the clock after accept; cmd_ready high again that cycle.
- Abort: inc=2^28, cycles=3; assert abort on the 20th RUN cycle ->
  - next cycle IDLE, lut_en=0, aborted=1 for one clock, burst_done=0, cycle_cnt=1.
  - abort with cmd_valid while IDLE -> no accept.
- Reset mid-RUN: rst_n=0 during RUN -> next cycle all outputs 0, no pulses; a new command after release starts from addr 0.
